// File: rtl/spmmio_pkg.sv
// Shared constants for the memory-mapped LED controller: register map,
// channel mode encodings and the blink terminal-count helper.
package spmmio_pkg;

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADR_W-1:0] ADR_OUT      = 4'd0;
  localparam logic [ADR_W-1:0] ADR_MODE     = 4'd1;
  localparam logic [ADR_W-1:0] ADR_PRESCALE = 4'd2;
  localparam logic [ADR_W-1:0] ADR_BLINK    = 4'd3;
  localparam logic [ADR_W-1:0] ADR_DUTY0    = 4'd4;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_GATED  = 2'b11
  } mode_e;

  // Last blink count before the phase flips; a half-period of 0 acts like 1.
  function automatic logic [7:0] blink_last(input logic [7:0] half);
    return (half == 8'd0) ? 8'd0 : 8'(half - 8'd1);
  endfunction

endpackage

// File: rtl/spmmio_led_chan.sv
// One LED channel: selects static, blink, pwm or blink-gated pwm drive.
module spmmio_led_chan
  import spmmio_pkg::*;
(
  input  mode_e       i_mode,
  input  logic        i_out,
  input  logic        i_phase,
  input  logic [7:0]  i_pwm_cnt,
  input  logic [7:0]  i_duty,
  output logic        o_led_c
);

  logic w_pwm;

  always_comb begin
    w_pwm   = (i_pwm_cnt < i_duty);
    o_led_c = 1'b0;
    case (i_mode)
      MODE_STATIC: o_led_c = i_out;
      MODE_BLINK:  o_led_c = i_out & i_phase;
      MODE_PWM:    o_led_c = w_pwm;
      MODE_GATED:  o_led_c = w_pwm & i_phase;
      default:     o_led_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/spmmio_leds.sv
// Memory-mapped LED controller: register file, prescaler, PWM and blink
// counters, and NUM_LEDS registered channel outputs.
module spmmio_leds
  import spmmio_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 2,
  parameter logic [15:0] PRESCALE_INIT = 16'd999,
  parameter logic [7:0]  BLINK_INIT    = 8'd100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:3]          adr,
  input  logic                cs,
  input  logic [0:3]          sel,
  input  logic                we,
  input  logic [0:31]         d,
  output logic [0:31]         q,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned MODE_W = 2 * NUM_LEDS;

  // Bus is big-endian bit numbered; internally bit 0 is the LSB.
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_rd;
  logic [3:0]        w_be;
  logic [ADR_W-1:0]  w_adr;
  logic              w_unused;

  assign w_wd     = d;
  assign w_be     = sel;
  assign w_adr    = adr;
  assign q        = w_rd;
  assign w_unused = ^{w_wd[31:16], w_be[3:2]};

  logic [NUM_LEDS-1:0] r_out;
  logic [MODE_W-1:0]   r_mode;
  logic [15:0]         r_prescale;
  logic [7:0]          r_blink;
  logic [7:0]          r_duty [NUM_LEDS];
  logic [15:0]         r_pre_cnt;
  logic [7:0]          r_pwm_cnt;
  logic [7:0]          r_blink_cnt;
  logic                r_phase;
  logic [NUM_LEDS-1:0] r_led;
  logic [NUM_LEDS-1:0] w_led_c;

  logic                w_wr;
  logic                w_wr_blink;
  logic                w_pre_touch;
  logic [15:0]         w_pre_new;
  logic [NUM_LEDS-1:0] w_duty_hit;
  logic                w_tick;
  logic                w_blink_wrap;

  assign w_wr        = cs & we;
  assign w_wr_blink  = w_wr && (w_adr == ADR_BLINK);
  assign w_pre_touch = w_wr && (w_adr == ADR_PRESCALE) && (w_be[1] | w_be[0]);
  assign w_pre_new   = {w_be[1] ? w_wd[15:8] : r_prescale[15:8],
                        w_be[0] ? w_wd[7:0]  : r_prescale[7:0]};
  assign w_tick       = (r_pre_cnt == 16'd0);
  assign w_blink_wrap = w_tick && (r_blink_cnt >= blink_last(r_blink));

  always_comb begin
    w_duty_hit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_duty_hit[i] = (w_adr == 4'(ADR_DUTY0 + i));
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_mode     <= '0;
      r_prescale <= PRESCALE_INIT;
      r_blink    <= BLINK_INIT;
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else begin
      if (w_wr && (w_adr == ADR_OUT) && w_be[0]) r_out <= w_wd[NUM_LEDS-1:0];
      if (w_wr && (w_adr == ADR_MODE)) begin
        for (int k = 0; k < MODE_W; k++) begin
          if (w_be[k/8]) r_mode[k] <= w_wd[k];
        end
      end
      if (w_pre_touch) r_prescale <= w_pre_new;
      if (w_wr_blink && w_be[0]) r_blink <= w_wd[7:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_wr && w_duty_hit[i] && w_be[0]) r_duty[i] <= w_wd[7:0];
      end
    end
  end

  // Prescaler, PWM and blink timebase; register writes win over tick updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= PRESCALE_INIT;
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (w_pre_touch)  r_pre_cnt <= w_pre_new;
      else if (w_tick)  r_pre_cnt <= r_prescale;
      else              r_pre_cnt <= r_pre_cnt - 16'd1;

      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 8'd1;

      if (w_wr_blink)        r_blink_cnt <= '0;
      else if (w_blink_wrap) r_blink_cnt <= '0;
      else if (w_tick)       r_blink_cnt <= r_blink_cnt + 8'd1;

      if (w_blink_wrap) r_phase <= ~r_phase;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    spmmio_led_chan u_chan (
      .i_mode    (mode_e'(r_mode[2*gi +: 2])),
      .i_out     (r_out[gi]),
      .i_phase   (r_phase),
      .i_pwm_cnt (r_pwm_cnt),
      .i_duty    (r_duty[gi]),
      .o_led_c   (w_led_c[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_led <= '0;
    else       r_led <= w_led_c;
  end

  assign led = r_led;

  // Combinational readback, independent of cs
  always_comb begin
    w_rd = '0;
    case (w_adr)
      ADR_OUT:      w_rd[NUM_LEDS-1:0] = r_led;
      ADR_MODE:     w_rd[MODE_W-1:0]   = r_mode;
      ADR_PRESCALE: w_rd[15:0]         = r_prescale;
      ADR_BLINK: begin
        w_rd[7:0] = r_blink;
        w_rd[31]  = r_phase;
      end
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (w_duty_hit[i]) w_rd[7:0] = r_duty[i];
        end
      end
    endcase
  end

endmodule
